// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end; credit-limited outstanding requests feeding an
// in-order {pc, instr} buffer toward decode, with redirect flush of stale responses.
module fetch_queue #(
    parameter int PC_W = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [PC_W-1:0]  mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [INS_W-1:0] mem_rsp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [INS_W-1:0] out_instr
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d, count_q, count_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [DEPTH-1:0][PC_W-1:0] pc_mem_q, pc_mem_d;
    logic [DEPTH-1:0][INS_W-1:0] ins_mem_q, ins_mem_d;
    logic [CW:0] used;
    logic req_hs, rsp, push, pop;

    // inflight counts every outstanding request, stale ones included, so discard never exceeds it
    always_comb begin
        used = {1'b0, inflight_q} + {1'b0, count_q};
        mem_req_valid = reset && !redirect && (used < (CW+1)'(DEPTH));
        mem_req_addr = fetch_pc_q;
        req_hs = mem_req_valid && mem_req_ready;
        rsp = mem_rsp_valid && (inflight_q != '0);
        push = rsp && (discard_q == '0) && !redirect;
        out_valid = (count_q != '0);
        pop = out_valid && out_ready && !redirect;
        out_pc = pc_mem_q[rd_q];
        out_instr = ins_mem_q[rd_q];
        fetch_pc_d = redirect ? redirect_pc : fetch_pc_q + (req_hs ? PC_W'(4) : PC_W'(0));
        rsp_pc_d = redirect ? redirect_pc : rsp_pc_q + (push ? PC_W'(4) : PC_W'(0));
        inflight_d = inflight_q + CW'(req_hs) - CW'(rsp);
        discard_d = redirect ? inflight_q - CW'(rsp) : discard_q - CW'(rsp && (discard_q != '0));
        count_d = redirect ? '0 : count_q + CW'(push) - CW'(pop);
        wr_d = redirect ? '0 : wr_q + AW'(push);
        rd_d = redirect ? '0 : rd_q + AW'(pop);
        pc_mem_d = pc_mem_q;
        ins_mem_d = ins_mem_q;
        if (push) begin
            pc_mem_d[wr_q] = rsp_pc_q;
            ins_mem_d[wr_q] = mem_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            inflight_q <= '0;
            discard_q <= '0;
            count_q <= '0;
            rd_q <= '0;
            wr_q <= '0;
            pc_mem_q <= '0;
            ins_mem_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q <= discard_d;
            count_q <= count_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            pc_mem_q <= pc_mem_d;
            ins_mem_q <= ins_mem_d;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized bench with an in-order memory model and a scoreboard of the
// expected {pc, instr} stream; the monitor checks on the falling edge.
module tb_fetch_queue;
    localparam int PC_W = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    logic clk = 0;
    logic reset = 0;
    logic redirect = 0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic mem_req_valid, mem_req_ready = 0;
    logic [PC_W-1:0] mem_req_addr;
    logic mem_rsp_valid = 0;
    logic [INS_W-1:0] mem_rsp_data = '0;
    logic out_valid, out_ready = 0;
    logic [PC_W-1:0] out_pc;
    logic [INS_W-1:0] out_instr;

    fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] ea;
        logic [PC_W-1:0] da;
        bit stale;
        int due;
    } req_t;
    typedef struct {
        logic [PC_W-1:0] pc;
        logic [INS_W-1:0] ins;
    } ent_t;

    req_t mem_q[$];
    ent_t exp_q[$];
    logic [PC_W-1:0] m_fetch = RESET_PC;
    int checks = 0, errors = 0;
    int cyc = 0, lat = 1;
    int rdy_pct = 100, ordy_pct = 100, redir_pct = 0, rsp_pct = 100;
    int tmo_cnt = 0, tmo_seen = 0;
    bit did_redir = 0;

    function automatic logic [INS_W-1:0] instr_of(input logic [PC_W-1:0] a);
        return INS_W'(a) * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // monitor and reference model: everything seen here is what the next rising edge captures
    always @(negedge clk) begin
        req_t h, r;
        ent_t e;
        bit hv;
        if (tmo_cnt != tmo_seen) begin
            chk("wait_budget", 64'(tmo_cnt), 64'(tmo_seen));
            tmo_seen = tmo_cnt;
        end
        if (!reset) begin
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_req_valid", 64'(mem_req_valid), 64'(0));
            chk("rst_out_pc", 64'(out_pc), 64'(0));
            chk("rst_out_instr", 64'(out_instr), 64'(0));
            chk("rst_req_addr", 64'(mem_req_addr), 64'(RESET_PC));
            mem_q.delete();
            exp_q.delete();
            m_fetch = RESET_PC;
        end else begin
            hv = exp_q.size() != 0;
            chk("out_valid", 64'(out_valid), 64'(hv));
            if (out_valid && hv) begin
                chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
                chk("out_instr", 64'(out_instr), 64'(exp_q[0].ins));
            end
            chk("req_valid", 64'(mem_req_valid),
                64'(!redirect && (mem_q.size() + exp_q.size() < DEPTH)));
            if (out_valid && out_ready && !redirect && hv) void'(exp_q.pop_front());
            if (mem_rsp_valid && mem_q.size() != 0) begin
                h = mem_q.pop_front();
                if (!h.stale && !redirect) begin
                    e.pc = h.ea;
                    e.ins = instr_of(h.ea);
                    exp_q.push_back(e);
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                chk("req_addr", 64'(mem_req_addr), 64'(m_fetch));
                r.ea = m_fetch;
                r.da = mem_req_addr;
                r.stale = 0;
                r.due = cyc + lat;
                mem_q.push_back(r);
                m_fetch = m_fetch + PC_W'(4);
            end
            if (redirect) begin
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].stale = 1;
                m_fetch = redirect_pc;
            end
        end
    end

    // mode: 0 random redirect, 1 forced, 2 when 3 requests in flight, 3 with a response and a pop
    task automatic step(input int mode = 0, input logic [PC_W-1:0] fpc = '0);
        bit fr;
        @(posedge clk);
        #1;
        cyc++;
        mem_req_ready = $urandom_range(99) < rdy_pct;
        out_ready = (mode == 3) || ($urandom_range(99) < ordy_pct);
        mem_rsp_valid = reset && mem_q.size() != 0 && mem_q[0].due <= cyc && $urandom_range(99) < rsp_pct;
        mem_rsp_data = mem_rsp_valid ? instr_of(mem_q[0].da) : $urandom;
        fr = (mode == 1) || (mode == 2 && mem_q.size() == 3) ||
             (mode == 3 && mem_rsp_valid && exp_q.size() != 0);
        redirect = reset && (fr || (mode == 0 && $urandom_range(99) < redir_pct));
        redirect_pc = fr ? fpc : PC_W'($urandom_range(127)) << 2;
        did_redir = fr;
    endtask

    task automatic wait_redir(input int mode, input logic [PC_W-1:0] fpc);
        int n = 0;
        do begin
            step(mode, fpc);
            n++;
        end while (!did_redir && n < 60);
        if (!did_redir) tmo_cnt++;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        cyc++;
        reset = 0;
        redirect = 0;
        mem_rsp_valid = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        reset = 1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1;
        lat = 1;
        repeat (20) step();
        ordy_pct = 0;
        repeat (10) step();
        ordy_pct = 100;
        repeat (15) step();
        pulse_reset();
        lat = 3;
        wait_redir(2, 9'h040);
        repeat (20) step();
        lat = 1;
        wait_redir(3, 9'h100);
        repeat (10) step();
        wait_redir(1, 9'h1F4);
        repeat (15) step();
        lat = 3;
        ordy_pct = 0;
        repeat (6) step();
        pulse_reset();
        ordy_pct = 100;
        repeat (20) step();
        for (int ph = 0; ph < 12; ph++) begin
            lat = $urandom_range(4, 1);
            rdy_pct = $urandom_range(100, 40);
            ordy_pct = $urandom_range(100, 30);
            redir_pct = $urandom_range(8, 0);
            rsp_pct = $urandom_range(100, 50);
            repeat (250) step();
            if (ph == 6) pulse_reset();
        end
        redir_pct = 0;
        ordy_pct = 100;
        rdy_pct = 100;
        rsp_pct = 100;
        repeat (20) step();
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
